lmsm_sequencer: RTL and testbench
=================================

LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

Interface
REQ-001 The block SHALL have the following ports, clock and reset first; `reset` is synchronous and active-high, and `clk` is the clock:
- clk  in  1  clock, all state changes on posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  request to begin a multi-register transfer (load-multiple LM or store-multiple SM)
- is_load  in  1  1 = LM (memory to register file), 0 = SM (register file to memory); sampled with start
- reg_mask  in  8  bit i set = register Ri takes part; sampled with start
- base_addr  in  16  first memory word address; sampled with start
- mem_ready  in  1  memory accepts or returns the current word this cycle
- busy  out  1  sequencer not IDLE
- stall  out  1  freeze upstream pipeline stages
- reg_addr  out  3  register-file address for the current transfer
- mem_addr  out  16  memory word address for the current transfer
- mem_req  out  1  memory access request, held until mem_ready
- mem_we  out  1  memory write strobe (SM)
- rf_we  out  1  register-file write enable (LM)
- xfer_count  out  4  registers transferred so far in the current operation
- done  out  1  one-cycle completion pulse

Function
REQ-002 The block SHALL implement three states: IDLE, XFER and DONE, with registered state.
REQ-003 In IDLE with start=1, the block SHALL latch is_load, reg_mask, base_addr and clear xfer_count.
- Non-zero mask: next state SHALL be XFER.
- Zero mask: next state SHALL be DONE.
REQ-004 While the block is not IDLE, start SHALL be ignored and the latched operands SHALL NOT change.
REQ-005 reg_addr SHALL equal the index of the lowest set bit of the remaining latched mask (lowest register first).
- reg_addr SHALL be 0 when the remaining mask is empty.
REQ-006 mem_addr SHALL be the latched base_addr plus the number of words already transferred, modulo 2^16; 16'hFFFF SHALL wrap to 16'h0000.
REQ-007 In XFER, mem_req SHALL be 1, mem_we SHALL equal !is_load, and rf_we SHALL equal is_load & mem_ready; these SHALL be combinational from state and inputs.
REQ-008 mem_req, mem_we, reg_addr and mem_addr SHALL stay stable in XFER until a cycle with mem_ready=1.
- mem_ready=0 SHALL insert wait states with no other state change.
REQ-009 On each XFER posedge with mem_ready=1, the block SHALL:
- clear the serviced mask bit;
- increment mem_addr and xfer_count by 1;
- move to DONE if that bit was the last set bit, otherwise remain in XFER.
REQ-010 Each XFER cycle with mem_ready=1 SHALL complete exactly one transfer; there SHALL be no idle cycle between consecutive transfers.
REQ-011 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-012 Outside XFER, mem_req, mem_we and rf_we SHALL be 0.
REQ-013 busy SHALL be 1 in XFER and DONE and 0 in IDLE.
REQ-014 stall SHALL equal busy OR (IDLE AND start), so the pipeline freezes in the same cycle the request appears.
REQ-015 xfer_count SHALL hold its final value through DONE and IDLE until the next accepted start.
- Maximum value is 8; the counter SHALL NOT wrap.
REQ-016 Minimum latency from start to done SHALL be:
- N+1 cycles for N set mask bits with mem_ready constantly high;
- 1 cycle for a zero mask.

Reset
REQ-017 With reset=1 at a posedge, the block SHALL enter IDLE and clear the latched mask, mem_addr, reg_addr, xfer_count and is_load.
REQ-018 In the cycle after reset, all outputs SHALL be 0.
REQ-019 Reset SHALL take priority over start and mem_ready.
REQ-020 Reset in XFER SHALL abort the operation with no further mem_req, mem_we or rf_we assertions and no done pulse.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- LM, mask=8'b1010_0101, base=16'h0040, mem_ready=1: reg_addr sequence 0,2,5,7; mem_addr sequence 0040,0041,0042,0043; rf_we for 4 cycles; done 5 cycles after start; xfer_count=4.
- SM, mask=8'h81, base=16'h0100, mem_ready low for 2 cycles on the first word: reg_addr=0 and mem_addr=0100 held 3 cycles with mem_we=1; then R7 at 0101; done; xfer_count=2.
- mask=8'h00 with start: done 1 cycle later; mem_req, mem_we and rf_we never asserted; stall high for 2 cycles.
- mask=8'hFF, base=16'hFFFE: mem_addr sequence FFFE,FFFF,0000,...,0005; xfer_count=8.
- start pulsed while busy with different operands: ignored; the original sequence completes unchanged.
- reset asserted on the 2nd transfer of mask=8'h0F: next cycle IDLE, all outputs 0, no done; a new start then runs normally.

Source files
------------

// File: rtl/lmsm_sequencer.sv
// Load-multiple / store-multiple sequencer: walks the latched register mask
// lowest register first, issuing one memory word per mem_ready handshake.
module lmsm_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic [7:0]  reg_mask,
  input  logic [15:0] base_addr,
  input  logic        mem_ready,
  output logic        busy,
  output logic        stall,
  output logic [2:0]  reg_addr,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic        rf_we,
  output logic [3:0]  xfer_count,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t      state;
  logic        load_q;
  logic [7:0]  mask_q;
  logic [15:0] base_q;
  logic [3:0]  count_q;
  logic [7:0]  mask_rest;

  // Remaining mask with its lowest set bit cleared.
  assign mask_rest = mask_q & (mask_q - 8'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      load_q  <= 1'b0;
      mask_q  <= '0;
      base_q  <= '0;
      count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            load_q  <= is_load;
            mask_q  <= reg_mask;
            base_q  <= base_addr;
            count_q <= '0;
            state   <= (reg_mask != 8'h00) ? XFER : DONE;
          end
        end
        XFER: begin
          if (mem_ready) begin
            mask_q <= mask_rest;
            if (count_q != 4'd8) count_q <= count_q + 4'd1;
            if (mask_rest == 8'h00) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    logic found;
    reg_addr = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (mask_q[i] && !found) begin
        reg_addr = 3'(i);
        found    = 1'b1;
      end
    end
  end

  assign mem_addr   = base_q + {12'd0, count_q};
  assign xfer_count = count_q;
  assign busy       = (state != IDLE);
  assign stall      = busy | (start & (state == IDLE));
  assign mem_req    = (state == XFER);
  assign mem_we     = (state == XFER) & ~load_q;
  assign rf_we      = (state == XFER) & load_q & mem_ready;
  assign done       = (state == DONE);

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer with hand-computed expectations.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, is_load, mem_ready;
  logic [7:0]  reg_mask;
  logic [15:0] base_addr;
  logic        busy, stall, mem_req, mem_we, rf_we, done;
  logic [2:0]  reg_addr;
  logic [15:0] mem_addr;
  logic [3:0]  xfer_count;

  int checks = 0;
  int failures = 0;

  lmsm_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load),
    .reg_mask(reg_mask), .base_addr(base_addr), .mem_ready(mem_ready),
    .busy(busy), .stall(stall), .reg_addr(reg_addr), .mem_addr(mem_addr),
    .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we),
    .xfer_count(xfer_count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] ra, input logic [15:0] ma,
                          input logic rq, input logic we, input logic rfw,
                          input logic bz, input logic dn);
    chk({tag, ".reg_addr"}, 16'(reg_addr), 16'(ra));
    chk({tag, ".mem_addr"}, mem_addr, ma);
    chk({tag, ".mem_req"},  16'(mem_req), 16'(rq));
    chk({tag, ".mem_we"},   16'(mem_we), 16'(we));
    chk({tag, ".rf_we"},    16'(rf_we), 16'(rfw));
    chk({tag, ".busy"},     16'(busy), 16'(bz));
    chk({tag, ".done"},     16'(done), 16'(dn));
  endtask

  initial begin
    logic [2:0] lm_regs [4];
    lm_regs = '{3'd0, 3'd2, 3'd5, 3'd7};

    reset = 1'b1; start = 1'b0; is_load = 1'b0; mem_ready = 1'b0;
    reg_mask = '0; base_addr = '0;
    step(); step();
    reset = 1'b0;
    #1;
    chk_outs("rst", 3'd0, 16'h0000, 0, 0, 0, 0, 0);
    chk("rst.stall", 16'(stall), 16'h0);
    chk("rst.count", 16'(xfer_count), 16'h0);

    // LM 8'b1010_0101 at 0x0040, memory always ready
    start = 1'b1; is_load = 1'b1; reg_mask = 8'hA5; base_addr = 16'h0040; mem_ready = 1'b1;
    #1;
    chk("lm.stall0", 16'(stall), 16'h1);
    chk("lm.busy0", 16'(busy), 16'h0);
    step();
    start = 1'b0; reg_mask = 8'h00; base_addr = 16'hDEAD;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk_outs($sformatf("lm.x%0d", k), lm_regs[k], 16'h0040 + 16'(k), 1, 0, 1, 1, 0);
      chk($sformatf("lm.x%0d.count", k), 16'(xfer_count), 16'(k));
      step();
    end
    chk_outs("lm.done", 3'd0, 16'h0044, 0, 0, 0, 1, 1);
    chk("lm.done.count", 16'(xfer_count), 16'h4);
    step();
    chk_outs("lm.idle", 3'd0, 16'h0044, 0, 0, 0, 0, 0);
    chk("lm.idle.count", 16'(xfer_count), 16'h4);

    // SM 8'h81 at 0x0100, two wait states on first word
    start = 1'b1; is_load = 1'b0; reg_mask = 8'h81; base_addr = 16'h0100; mem_ready = 1'b0;
    step();
    start = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) mem_ready = 1'b1;
      #1;
      chk_outs($sformatf("sm.w%0d", k), 3'd0, 16'h0100, 1, 1, 0, 1, 0);
      chk($sformatf("sm.w%0d.count", k), 16'(xfer_count), 16'h0);
      step();
    end
    chk_outs("sm.r7", 3'd7, 16'h0101, 1, 1, 0, 1, 0);
    step();
    chk_outs("sm.done", 3'd0, 16'h0102, 0, 0, 0, 1, 1);
    chk("sm.count", 16'(xfer_count), 16'h2);
    step();

    // Zero mask
    start = 1'b1; is_load = 1'b1; reg_mask = 8'h00; base_addr = 16'h0500;
    #1;
    chk("zero.stall0", 16'(stall), 16'h1);
    chk("zero.req0", 16'(mem_req), 16'h0);
    step();
    start = 1'b0;
    #1;
    chk_outs("zero.done", 3'd0, 16'h0500, 0, 0, 0, 1, 1);
    chk("zero.stall1", 16'(stall), 16'h1);
    chk("zero.count", 16'(xfer_count), 16'h0);
    step();
    chk("zero.stall2", 16'(stall), 16'h0);
    chk("zero.done2", 16'(done), 16'h0);

    // Full mask with address wrap
    start = 1'b1; is_load = 1'b1; reg_mask = 8'hFF; base_addr = 16'hFFFE;
    step();
    start = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk_outs($sformatf("ff.x%0d", k), 3'(k), 16'hFFFE + 16'(k), 1, 0, 1, 1, 0);
      step();
    end
    chk("ff.done", 16'(done), 16'h1);
    chk("ff.count", 16'(xfer_count), 16'h8);
    chk("ff.addr", mem_addr, 16'h0006);
    step();

    // start while busy is ignored
    start = 1'b1; is_load = 1'b1; reg_mask = 8'h06; base_addr = 16'h0200;
    step();
    reg_mask = 8'hF0; base_addr = 16'h1234; is_load = 1'b0;
    #1;
    chk_outs("ign.x0", 3'd1, 16'h0200, 1, 0, 1, 1, 0);
    chk("ign.stall", 16'(stall), 16'h1);
    step();
    start = 1'b0;
    #1;
    chk_outs("ign.x1", 3'd2, 16'h0201, 1, 0, 1, 1, 0);
    step();
    chk_outs("ign.done", 3'd0, 16'h0202, 0, 0, 0, 1, 1);
    chk("ign.count", 16'(xfer_count), 16'h2);
    step();

    // Reset during second transfer of 8'h0F
    start = 1'b1; is_load = 1'b1; reg_mask = 8'h0F; base_addr = 16'h0030;
    step();
    start = 1'b0;
    #1;
    chk_outs("ab.x0", 3'd0, 16'h0030, 1, 0, 1, 1, 0);
    step();
    chk_outs("ab.x1", 3'd1, 16'h0031, 1, 0, 1, 1, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk_outs("ab.rst", 3'd0, 16'h0000, 0, 0, 0, 0, 0);
    chk("ab.stall", 16'(stall), 16'h0);
    chk("ab.count", 16'(xfer_count), 16'h0);
    step();
    chk("ab.nodone", 16'(done), 16'h0);
    chk("ab.noreq", 16'(mem_req), 16'h0);

    // Restart after abort: SM 8'h03 at 0x0010
    start = 1'b1; is_load = 1'b0; reg_mask = 8'h03; base_addr = 16'h0010;
    step();
    start = 1'b0;
    #1;
    chk_outs("re.x0", 3'd0, 16'h0010, 1, 1, 0, 1, 0);
    step();
    chk_outs("re.x1", 3'd1, 16'h0011, 1, 1, 0, 1, 0);
    step();
    chk_outs("re.done", 3'd0, 16'h0012, 0, 0, 0, 1, 1);
    chk("re.count", 16'(xfer_count), 16'h2);
    step();
    chk("re.idle", 16'(busy), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
